mux_n_to_1_rr_reg: RTL and testbench

- Parametrised, registered N:1 datapath multiplexer for the CPU/packet datapath. It generalises the fixed 64-bit 2:1 select to N_IN channels of WIDTH bits.
- Each channel has a valid/ready handshake. Selection is made by an internal round-robin arbiter instead of an external select line.
- An optional packet mode holds the grant on one channel until that channel's last beat is accepted.
- Sits between multiple producers (e.g. pipeline stages, FIFOs) and a single consumer. It provides one output register stage.

---
 rtl/mux_n_to_1_rr_reg_pkg.sv | 20 ++
 rtl/mux_n_to_1_rr_arbiter.sv | 52 +++++
 rtl/mux_n_to_1_rr_reg.sv | 110 +++++++++++
 tb/tb_mux_n_to_1_rr_reg.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_n_to_1_rr_reg_pkg.sv
// Shared definitions for the round-robin registered N:1 multiplexer:
// width helpers and the arbitration mode encodings.
package mux_n_to_1_rr_reg_pkg;

  localparam int MODE_BEAT = 0;
  localparam int MODE_PKT  = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Select fields are never narrower than one bit, even for a single channel.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_to_1_rr_arbiter.sv
// Round-robin request arbiter: cyclic first-valid search starting at the
// pointer, or a fixed grant to the locked channel while a packet is in flight.
module rr_arbiter_n
  import mux_n_to_1_rr_reg_pkg::*;
#(
  parameter  int N_IN  = 4,
  localparam int SEL_W = sel_width(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             lock,
  input  logic [SEL_W-1:0] lock_idx,
  output logic [N_IN-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_vld
);

  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                 input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= N_IN) s = s - N_IN;
    return SEL_W'(s);
  endfunction

  logic [SEL_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    if (lock) begin
      // A locked channel that is momentarily idle still blocks everyone else.
      if (req[lock_idx]) begin
        grant[lock_idx] = 1'b1;
        grant_idx       = lock_idx;
        grant_vld       = 1'b1;
      end
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        cand = wrap_add(ptr, k);
        if (!grant_vld && req[cand]) begin
          grant[cand] = 1'b1;
          grant_idx   = cand;
          grant_vld   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_n_to_1_rr_reg.sv
// Registered N:1 datapath multiplexer with per-channel valid/ready and a
// round-robin arbiter; optional packet mode holds the grant until in_last.
module mux_n_to_1_rr_reg
  import mux_n_to_1_rr_reg_pkg::*;
#(
  parameter  int WIDTH    = 64,
  parameter  int N_IN     = 4,
  parameter  int PKT_MODE = MODE_BEAT,
  localparam int SEL_W    = sel_width(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_vld,
  input  logic [N_IN-1:0]       in_last,
  output logic [N_IN-1:0]       in_rdy,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_vld,
  input  logic                  out_rdy
);

  localparam bit USE_LOCK = (PKT_MODE == MODE_PKT);

  function automatic logic [SEL_W-1:0] ptr_next(input logic [SEL_W-1:0] idx);
    if (idx == SEL_W'(N_IN - 1)) return '0;
    return idx + 1'b1;
  endfunction

  logic [SEL_W-1:0] ptr;
  logic             lock;
  logic [SEL_W-1:0] lock_idx;

  logic [N_IN-1:0]  grant_p0;
  logic [SEL_W-1:0] grant_idx_p0;
  logic             grant_vld_p0;
  logic             load_en_p0;
  logic             accept_p0;
  logic [WIDTH-1:0] sel_data_p0;
  logic             sel_last_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic             last_p1;
  logic [SEL_W-1:0] sel_p1;

  // ---- stage p0: arbitration and selection ----
  rr_arbiter_n #(
    .N_IN(N_IN)
  ) u_arb (
    .req      (in_vld),
    .ptr      (ptr),
    .lock     (lock),
    .lock_idx (lock_idx),
    .grant    (grant_p0),
    .grant_idx(grant_idx_p0),
    .grant_vld(grant_vld_p0)
  );

  assign load_en_p0  = !vld_p1 || out_rdy;
  assign accept_p0   = grant_vld_p0 && load_en_p0 && !reset;
  assign in_rdy      = grant_p0 & {N_IN{load_en_p0 && !reset}};
  assign sel_data_p0 = in_data[grant_idx_p0*WIDTH +: WIDTH];
  assign sel_last_p0 = in_last[grant_idx_p0];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (accept_p0) begin
      if (USE_LOCK && !sel_last_p0) begin
        lock     <= 1'b1;
        lock_idx <= grant_idx_p0;
      end else begin
        lock <= 1'b0;
        ptr  <= ptr_next(grant_idx_p0);
      end
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      sel_p1  <= '0;
    end else if (load_en_p0) begin
      vld_p1 <= accept_p0;
      if (accept_p0) begin
        data_p1 <= sel_data_p0;
        last_p1 <= sel_last_p0;
        sel_p1  <= grant_idx_p0;
      end
    end
  end

  assign out_vld  = vld_p1;
  assign out_data = data_p1;
  assign out_last = last_p1;
  assign out_sel  = sel_p1;

  a_rdy_onehot: assert property (@(posedge clk) $onehot0(in_rdy));

  a_stall_hold: assert property (@(posedge clk) disable iff (reset)
    (out_vld && !out_rdy) |=> (out_vld && $stable(out_data) && $stable(out_sel)));

endmodule

// File: tb/tb_mux_n_to_1_rr_reg.sv
// Bench for mux_n_to_1_rr_reg: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbiter and register.
module tb_mux_n_to_1_rr_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int err = 0;

  logic         rst;
  logic [255:0] a_data;
  logic [3:0]   a_vld, a_last;
  logic         a_ordy;
  logic [3:0]   rdy0, rdy1;
  logic [63:0]  od0, od1;
  logic         ol0, ol1, ov0, ov1;
  logic [1:0]   os0, os1;

  logic [63:0]  b_data;
  logic [1:0]   b_vld, b_last, b_rdy;
  logic         b_ordy;
  logic [31:0]  b_od;
  logic         b_ol, b_os, b_ov;

  mux_n_to_1_rr_reg #(.WIDTH(64), .N_IN(4), .PKT_MODE(0)) dut_beat (
    .clk(clk), .reset(rst), .in_data(a_data), .in_vld(a_vld), .in_last(a_last),
    .in_rdy(rdy0), .out_data(od0), .out_last(ol0), .out_sel(os0), .out_vld(ov0),
    .out_rdy(a_ordy));

  mux_n_to_1_rr_reg #(.WIDTH(64), .N_IN(4), .PKT_MODE(1)) dut_pkt (
    .clk(clk), .reset(rst), .in_data(a_data), .in_vld(a_vld), .in_last(a_last),
    .in_rdy(rdy1), .out_data(od1), .out_last(ol1), .out_sel(os1), .out_vld(ov1),
    .out_rdy(a_ordy));

  mux_n_to_1_rr_reg #(.WIDTH(32), .N_IN(2), .PKT_MODE(0)) dut_n2 (
    .clk(clk), .reset(rst), .in_data(b_data), .in_vld(b_vld), .in_last(b_last),
    .in_rdy(b_rdy), .out_data(b_od), .out_last(b_ol), .out_sel(b_os), .out_vld(b_ov),
    .out_rdy(b_ordy));

  // pm selects which 4-channel instance the model tracks (0 beat, 1 packet).
  bit          pm = 1'b0;
  logic [3:0]  c_rdy;
  logic [63:0] c_od;
  logic        c_ol, c_ov;
  logic [1:0]  c_os;

  always_comb begin
    c_rdy = pm ? rdy1 : rdy0;
    c_od  = pm ? od1  : od0;
    c_ol  = pm ? ol1  : ol0;
    c_ov  = pm ? ov1  : ov0;
    c_os  = pm ? os1  : os0;
  end

  // Reference model: pointer / lock / output register kept as plain integers.
  int          m_ptr = 0, m_lidx = 0, m_osel = 0;
  bit          m_lock = 1'b0, m_ovld = 1'b0, m_olast = 1'b0;
  logic [63:0] m_odata = '0;
  int          e_g;
  bit          e_load;
  logic [3:0]  e_rdy;

  always_comb begin
    int c;
    c      = 0;
    e_load = !m_ovld || a_ordy;
    e_g    = -1;
    if (m_lock) begin
      if (a_vld[m_lidx[1:0]]) e_g = m_lidx;
    end else begin
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (e_g < 0 && a_vld[c[1:0]]) e_g = c;
      end
    end
    e_rdy = (e_load && e_g >= 0 && !rst) ? (4'b0001 << e_g) : 4'b0000;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_ptr <= 0; m_lock <= 1'b0; m_lidx <= 0;
      m_ovld <= 1'b0; m_odata <= '0; m_olast <= 1'b0; m_osel <= 0;
    end else if (e_load) begin
      if (e_g >= 0) begin
        m_ovld  <= 1'b1;
        m_odata <= a_data[e_g*64 +: 64];
        m_olast <= a_last[e_g];
        m_osel  <= e_g;
        if (pm && !a_last[e_g]) begin
          m_lock <= 1'b1;
          m_lidx <= e_g;
        end else begin
          m_lock <= 1'b0;
          m_ptr  <= (e_g + 1) % 4;
        end
      end else begin
        m_ovld <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_data = '0; a_vld = '0; a_last = '0; a_ordy = 1'b1;
    b_data = '0; b_vld = '0; b_last = '0; b_ordy = 1'b1;
  endtask

  task automatic do_reset(input bit mode);
    pm  = mode;
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    a_vld = 4'hF; a_data = {4{64'h0123_4567_89AB_CDEF}};
    b_vld = 2'b11;
    repeat (2) begin
      @(negedge clk);
      vec++; if (rdy0 !== 4'b0000) begin err++; $display("FAIL reset_rdy_beat: got %b expected 0000", rdy0); end
      vec++; if (rdy1 !== 4'b0000) begin err++; $display("FAIL reset_rdy_pkt: got %b expected 0000", rdy1); end
      vec++; if (b_rdy !== 2'b00) begin err++; $display("FAIL reset_rdy_n2: got %b expected 00", b_rdy); end
      vec++; if (ov0 !== 1'b0) begin err++; $display("FAIL reset_vld: got %b expected 0", ov0); end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    vec++; if (ov0 !== 1'b0 || ov1 !== 1'b0 || b_ov !== 1'b0) begin err++; $display("FAIL idle_vld: got %b%b%b expected 000", ov0, ov1, b_ov); end
    vec++; if (rdy0 !== 4'b0000) begin err++; $display("FAIL idle_rdy: got %b expected 0000", rdy0); end
    vec++; if (od0 !== 64'h0 || os0 !== 2'd0 || ol0 !== 1'b0) begin err++; $display("FAIL idle_data: got %h/%0d/%b expected 0/0/0", od0, os0, ol0); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] er;
    do_reset(1'b0);
    a_vld = 4'hF; a_last = 4'hF; a_ordy = 1'b1;
    for (int i = 0; i < 4; i++) a_data[i*64 +: 64] = 64'hA0 + 64'(i);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      er = 4'b0001 << (c % 4);
      vec++; if (rdy0 !== er) begin err++; $display("FAIL rr_rdy c%0d: got %b expected %b", c, rdy0, er); end
      if (c == 0) begin
        vec++; if (ov0 !== 1'b0) begin err++; $display("FAIL rr_first_vld: got %b expected 0", ov0); end
      end else begin
        vec++; if (ov0 !== 1'b1 || os0 !== 2'((c - 1) % 4)) begin err++; $display("FAIL rr_sel c%0d: got vld %b sel %0d expected 1/%0d", c, ov0, os0, (c - 1) % 4); end
        vec++; if (od0 !== 64'hA0 + 64'((c - 1) % 4)) begin err++; $display("FAIL rr_data c%0d: got %h expected %h", c, od0, 64'hA0 + 64'((c - 1) % 4)); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    a_vld = 4'b0100; a_last = 4'hF; a_ordy = 1'b1;
    a_data[128 +: 64] = 64'hDEADBEEF_00000002;
    @(negedge clk);
    vec++; if (rdy0 !== 4'b0100) begin err++; $display("FAIL bp_first_rdy: got %b expected 0100", rdy0); end
    tick();
    a_data[128 +: 64] = 64'hDEADBEEF_00000003;
    a_ordy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vec++; if (rdy0 !== 4'b0000) begin err++; $display("FAIL bp_stall_rdy c%0d: got %b expected 0000", c, rdy0); end
      vec++; if (ov0 !== 1'b1 || od0 !== 64'hDEADBEEF_00000002 || os0 !== 2'd2) begin err++; $display("FAIL bp_stall_hold c%0d: got %b/%h/%0d expected 1/deadbeef00000002/2", c, ov0, od0, os0); end
      tick();
    end
    a_ordy = 1'b1;
    @(negedge clk);
    vec++; if (rdy0 !== 4'b0100) begin err++; $display("FAIL bp_release_rdy: got %b expected 0100", rdy0); end
    tick();
    a_vld = 4'b0000;
    @(negedge clk);
    vec++; if (ov0 !== 1'b1 || od0 !== 64'hDEADBEEF_00000003) begin err++; $display("FAIL bp_next_beat: got %b/%h expected 1/deadbeef00000003", ov0, od0); end
    tick();
  endtask

  task automatic test_packet_lock();
    do_reset(1'b1);
    a_ordy = 1'b1;
    a_vld = 4'b0001; a_last = 4'b0001; a_data[0 +: 64] = 64'hC0;
    @(negedge clk);
    vec++; if (rdy1 !== 4'b0001) begin err++; $display("FAIL pkt_pre_rdy: got %b expected 0001", rdy1); end
    tick();
    a_vld = 4'b1011; a_last = 4'b1001; a_data[64 +: 64] = 64'hB1; a_data[192 +: 64] = 64'hC3;
    @(negedge clk);
    vec++; if (rdy1 !== 4'b0010) begin err++; $display("FAIL pkt_beat1_rdy: got %b expected 0010", rdy1); end
    tick();
    a_data[64 +: 64] = 64'hB2;
    @(negedge clk);
    vec++; if (rdy1 !== 4'b0010) begin err++; $display("FAIL pkt_beat2_rdy: got %b expected 0010", rdy1); end
    vec++; if (ov1 !== 1'b1 || od1 !== 64'hB1 || os1 !== 2'd1 || ol1 !== 1'b0) begin err++; $display("FAIL pkt_beat1_out: got %b/%h/%0d/%b expected 1/b1/1/0", ov1, od1, os1, ol1); end
    tick();
    a_vld = 4'b1001;
    @(negedge clk);
    vec++; if (rdy1 !== 4'b0000) begin err++; $display("FAIL pkt_idle_locked_rdy: got %b expected 0000", rdy1); end
    tick();
    a_vld = 4'b1011; a_last = 4'b1011; a_data[64 +: 64] = 64'hB3;
    @(negedge clk);
    vec++; if (rdy1 !== 4'b0010) begin err++; $display("FAIL pkt_beat3_rdy: got %b expected 0010", rdy1); end
    vec++; if (ov1 !== 1'b0) begin err++; $display("FAIL pkt_bubble: got %b expected 0", ov1); end
    tick();
    a_vld = 4'b1001;
    @(negedge clk);
    vec++; if (rdy1 !== 4'b1000) begin err++; $display("FAIL pkt_after_rdy: got %b expected 1000", rdy1); end
    vec++; if (ov1 !== 1'b1 || od1 !== 64'hB3 || ol1 !== 1'b1) begin err++; $display("FAIL pkt_beat3_out: got %b/%h/%b expected 1/b3/1", ov1, od1, ol1); end
    tick();
    a_vld = 4'b0000;
    @(negedge clk);
    vec++; if (os1 !== 2'd3 || od1 !== 64'hC3) begin err++; $display("FAIL pkt_after_sel: got %0d/%h expected 3/c3", os1, od1); end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    do_reset(1'b1);
    a_ordy = 1'b1;
    a_vld = 4'b0100; a_last = 4'b0000;
    @(negedge clk);
    vec++; if (rdy1 !== 4'b0100) begin err++; $display("FAIL rmp_beat1_rdy: got %b expected 0100", rdy1); end
    tick();
    rst = 1'b1; a_vld = 4'b0101;
    @(negedge clk);
    vec++; if (rdy1 !== 4'b0000) begin err++; $display("FAIL rmp_in_reset_rdy: got %b expected 0000", rdy1); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    vec++; if (ov1 !== 1'b0) begin err++; $display("FAIL rmp_vld_dropped: got %b expected 0", ov1); end
    vec++; if (rdy1 !== 4'b0001) begin err++; $display("FAIL rmp_first_grant: got %b expected 0001", rdy1); end
    tick();
    a_vld = 4'b0000;
    @(negedge clk);
    vec++; if (ov1 !== 1'b1 || os1 !== 2'd0) begin err++; $display("FAIL rmp_out: got %b/%0d expected 1/0", ov1, os1); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset(1'b0);
    a_ordy = 1'b1; a_last = 4'hF;
    a_vld = 4'b0100;
    @(negedge clk);
    vec++; if (rdy0 !== 4'b0100) begin err++; $display("FAIL wrap_setup_rdy: got %b expected 0100", rdy0); end
    tick();
    a_vld = 4'b1001;
    @(negedge clk);
    vec++; if (rdy0 !== 4'b1000) begin err++; $display("FAIL wrap_ch3_first: got %b expected 1000", rdy0); end
    tick();
    @(negedge clk);
    vec++; if (rdy0 !== 4'b0001 || os0 !== 2'd3) begin err++; $display("FAIL wrap_ch0_next: got %b/%0d expected 0001/3", rdy0, os0); end
    tick();
    a_vld = 4'b0000;
    @(negedge clk);
    vec++; if (os0 !== 2'd0) begin err++; $display("FAIL wrap_sel0: got %0d expected 0", os0); end
    // two-channel, 32-bit instance: toggle pointer
    b_data = {32'hC1, 32'hC0}; b_last = 2'b11; b_ordy = 1'b1;
    b_vld = 2'b01;
    tick();
    @(negedge clk);
    vec++; if (b_rdy !== 2'b01) begin err++; $display("FAIL n2_setup_rdy: got %b expected 01", b_rdy); end
    tick();
    b_vld = 2'b11;
    @(negedge clk);
    vec++; if (b_rdy !== 2'b10) begin err++; $display("FAIL n2_grant1: got %b expected 10", b_rdy); end
    tick();
    @(negedge clk);
    vec++; if (b_rdy !== 2'b01 || b_os !== 1'b1 || b_od !== 32'hC1) begin err++; $display("FAIL n2_grant0: got %b/%b/%h expected 01/1/c1", b_rdy, b_os, b_od); end
    tick();
    @(negedge clk);
    vec++; if (b_rdy !== 2'b10 || b_os !== 1'b0 || b_od !== 32'hC0) begin err++; $display("FAIL n2_toggle: got %b/%b/%h expected 10/0/c0", b_rdy, b_os, b_od); end
    tick();
    b_vld = 2'b00;
  endtask

  task automatic test_random();
    for (int mode = 0; mode < 2; mode++) begin
      do_reset(mode[0]);
      for (int c = 0; c < 400; c++) begin
        for (int i = 0; i < 4; i++) a_data[i*64 +: 64] = {$urandom, $urandom};
        a_vld  = 4'($urandom);
        a_last = 4'($urandom);
        a_ordy = ($urandom_range(0, 3) != 0);
        rst    = ($urandom_range(0, 59) == 0);
        @(negedge clk);
        vec++; if (c_rdy !== e_rdy) begin err++; $display("FAIL rnd_rdy m%0d c%0d: got %b expected %b", mode, c, c_rdy, e_rdy); end
        vec++; if (c_ov !== m_ovld) begin err++; $display("FAIL rnd_vld m%0d c%0d: got %b expected %b", mode, c, c_ov, m_ovld); end
        vec++; if (c_od !== m_odata || c_os !== 2'(m_osel) || c_ol !== m_olast) begin err++; $display("FAIL rnd_out m%0d c%0d: got %h/%0d/%b expected %h/%0d/%b", mode, c, c_od, c_os, c_ol, m_odata, m_osel, m_olast); end
        tick();
      end
      rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_packet_lock();
    test_reset_mid_packet();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
